// File: rtl/bcd_seg_display.sv
// bcd_seg_display: binary -> BCD (double-dabble, one bit per clock) -> registered active-low 7-segment digits
// Ports: clk, rst_n (async, active-low); start/value request a conversion; busy while converting;
// done pulses for one cycle when segments/ovf update; ovf = value >= 10^DIGITS;
// segments[0:6] = MSD a..g, last 7 bits = units digit.
module bcd_seg_display #(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [0:7*DIGITS-1] segments
);
  localparam int NB = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    pow10 = 64'd1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0: dec7 = 7'b0000001;
      4'd1: dec7 = 7'b1001111;
      4'd2: dec7 = 7'b0010010;
      4'd3: dec7 = 7'b0000110;
      4'd4: dec7 = 7'b1001100;
      4'd5: dec7 = 7'b0100100;
      4'd6: dec7 = 7'b0100000;
      4'd7: dec7 = 7'b0001111;
      4'd8: dec7 = 7'b0000000;
      4'd9: dec7 = 7'b0000100;
      default: dec7 = 7'b1111110;
    endcase
  endfunction

  // Digit k counts from the most-significant digit, matching the ascending segments range.
  function automatic logic [0:SW-1] encode(input logic [NB-1:0] b, input logic ov);
    logic       lead;
    logic [3:0] n;
    encode = '0;
    lead = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      n = b[4*(DIGITS-1-k) +: 4];
      if (ov) encode[7*k +: 7] = 7'b1111110;
      else if (BLANK_LZ != 0 && lead && n == 4'd0 && k != DIGITS - 1) encode[7*k +: 7] = 7'b1111111;
      else begin
        encode[7*k +: 7] = dec7(n);
        lead = 1'b0;
      end
    end
  endfunction

  localparam logic [63:0]   LIMIT   = pow10(DIGITS);
  localparam logic [0:SW-1] SEG_RST = encode('0, 1'b0);

  logic [1:0]       state;
  logic [WIDTH-1:0] bin;
  logic [NB-1:0]    bcd, bcd_adj;
  logic [CW-1:0]    cnt;
  logic             ovf_p;

  assign busy = state != IDLE;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_p    <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      segments <= SEG_RST;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          bin   <= value;
          bcd   <= '0;
          cnt   <= CW'(WIDTH);
          ovf_p <= 64'(value) >= LIMIT;
          state <= CONV;
        end
      end else if (state == CONV) begin
        {bcd, bin} <= {bcd_adj, bin} << 1;
        cnt        <= cnt - 1'b1;
        state      <= cnt == CW'(1) ? LOAD : CONV;
      end else begin
        segments <= encode(bcd, ovf_p);
        ovf      <= ovf_p;
        done     <= 1'b1;
        state    <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bcd_seg_display.sv
// tb_bcd_seg_display: scoreboard bench for three bcd_seg_display configurations
module tb_bcd_seg_display;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [3:0] value0 = '0;
  logic [7:0] value1 = '0, value2 = '0;
  logic busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic [0:13] seg0, seg1;
  logic [0:20] seg2;
  logic [21:0] q0[$], q1[$], q2[$];
  logic [21:0] e0, e1, e2;
  int checks = 0, errors = 0, cyc = 0;

  bcd_seg_display u0 (.clk(clk), .rst_n(rst_n), .start(start0), .value(value0),
    .busy(busy0), .done(done0), .ovf(ovf0), .segments(seg0));
  bcd_seg_display #(.WIDTH(8), .DIGITS(2)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .value(value1),
    .busy(busy1), .done(done1), .ovf(ovf1), .segments(seg1));
  bcd_seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) u2 (.clk(clk), .rst_n(rst_n), .start(start2), .value(value2),
    .busy(busy2), .done(done2), .ovf(ovf2), .segments(seg2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done0) begin
      checks++;
      if (busy0) begin errors++; $display("FAIL busy_done0 busy=1 with done=1 expected busy=0"); end
      if (q0.size() == 0) begin errors++; $display("FAIL out0 unexpected done got=%b", {ovf0, seg0}); end
      else begin
        e0 = q0.pop_front();
        if ({7'b0, ovf0, seg0} !== e0) begin errors++; $display("FAIL out0 got=%b exp=%b", {7'b0, ovf0, seg0}, e0); end
      end
    end
    if (done1) begin
      checks++;
      if (busy1) begin errors++; $display("FAIL busy_done1 busy=1 with done=1 expected busy=0"); end
      if (q1.size() == 0) begin errors++; $display("FAIL out1 unexpected done got=%b", {ovf1, seg1}); end
      else begin
        e1 = q1.pop_front();
        if ({7'b0, ovf1, seg1} !== e1) begin errors++; $display("FAIL out1 got=%b exp=%b", {7'b0, ovf1, seg1}, e1); end
      end
    end
    if (done2) begin
      checks++;
      if (busy2) begin errors++; $display("FAIL busy_done2 busy=1 with done=1 expected busy=0"); end
      if (q2.size() == 0) begin errors++; $display("FAIL out2 unexpected done got=%b", {ovf2, seg2}); end
      else begin
        e2 = q2.pop_front();
        if ({ovf2, seg2} !== e2) begin errors++; $display("FAIL out2 got=%b exp=%b", {ovf2, seg2}, e2); end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s got=%h exp=%h", name, got, exp); end
  endtask

  task automatic issue(input int id, input logic [7:0] v, input logic [21:0] e);
    case (id)
      0: begin value0 = v[3:0]; start0 = 1'b1; q0.push_back(e); end
      1: begin value1 = v; start1 = 1'b1; q1.push_back(e); end
      default: begin value2 = v; start2 = 1'b1; q2.push_back(e); end
    endcase
  endtask

  task automatic finish_run(input int id, input bit hold, output int nb);
    bit seen = 1'b0;
    nb = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!hold) begin start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; end
      if (id == 0 ? busy0 : id == 1 ? busy1 : busy2) nb++;
      if (id == 0 ? done0 : id == 1 ? done1 : done2) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout%0d got=no_done exp=done", id); end
  endtask

  int nb, t1, t2;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst0", {ovf0, busy0, done0, seg0}, {3'b0, 14'b0000001_0000001});
    chk("rst1", {ovf1, busy1, done1, seg1}, {3'b0, 14'b0000001_0000001});
    chk("rst2", {ovf2, busy2, done2, seg2}, {3'b0, 21'b1111111_1111111_0000001});
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle0", {ovf0, busy0, done0, seg0}, {3'b0, 14'b0000001_0000001});
    chk("idle2", {ovf2, busy2, done2, seg2}, {3'b0, 21'b1111111_1111111_0000001});

    issue(0, 8'd9, {1'b0, 14'b0000001_0000100});
    finish_run(0, 1'b0, nb);
    chk("busy_len0", nb, 5);
    issue(0, 8'd15, {1'b0, 14'b1001111_0100100});
    finish_run(0, 1'b0, nb);
    issue(0, 8'd0, {1'b0, 14'b0000001_0000001});
    finish_run(0, 1'b0, nb);

    issue(1, 8'd100, {1'b1, 14'b1111110_1111110});
    finish_run(1, 1'b0, nb);
    chk("busy_len1", nb, 9);
    chk("ovf_hold1", {ovf1, seg1}, {1'b1, 14'b1111110_1111110});
    issue(1, 8'd99, {1'b0, 14'b0000100_0000100});
    finish_run(1, 1'b0, nb);
    issue(1, 8'd255, {1'b1, 14'b1111110_1111110});
    finish_run(1, 1'b0, nb);

    issue(2, 8'd7, {1'b0, 21'b1111111_1111111_0001111});
    finish_run(2, 1'b0, nb);
    issue(2, 8'd0, {1'b0, 21'b1111111_1111111_0000001});
    finish_run(2, 1'b0, nb);
    issue(2, 8'd205, {1'b0, 21'b0010010_0000001_0100100});
    finish_run(2, 1'b0, nb);
    issue(2, 8'd50, {1'b0, 21'b1111111_0100100_0000001});
    finish_run(2, 1'b0, nb);
    issue(2, 8'd255, {1'b0, 21'b0010010_0100100_0100100});
    finish_run(2, 1'b0, nb);

    issue(0, 8'd3, {1'b0, 14'b0000001_0000110});
    finish_run(0, 1'b1, nb);
    t1 = cyc;
    value0 = 4'd5;
    q0.push_back({1'b0, 14'b0000001_0100100});
    finish_run(0, 1'b1, nb);
    t2 = cyc;
    start0 = 1'b0;
    chk("b2b_period", t2 - t1, 6);

    issue(0, 8'd6, {1'b0, 14'b0000001_0100000});
    @(negedge clk) start0 = 1'b0;
    @(negedge clk) begin start0 = 1'b1; value0 = 4'd2; end
    @(negedge clk) start0 = 1'b0;
    finish_run(0, 1'b0, nb);
    repeat (12) @(negedge clk);

    value0 = 4'd8;
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid0", {ovf0, busy0, done0, seg0}, {3'b0, 14'b0000001_0000001});
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(0, 8'd8, {1'b0, 14'b0000001_0000000});
    finish_run(0, 1'b0, nb);
    repeat (3) @(negedge clk);
    chk("queues_empty", q0.size() + q1.size() + q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
